// File: rtl/pic_host_interface.sv
// CPU-side bus master for an 8259A PIC: runs queued RD/WR register cycles and
// autonomously performs the two-pulse INTA acknowledge, capturing the vector.
module pic_host_interface #(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic       cmd_a0,
   input  logic [7:0] cmd_data,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       irq_enable,
   output logic [7:0] vector,
   output logic       vector_valid,
   input  logic       INT,
   output logic       INTA,
   output logic       RD,
   output logic       WR,
   output logic       CS,
   output logic       A0,
   output logic [7:0] data_out,
   output logic       data_oe,
   input  logic [7:0] data_in
);

   localparam int MAX_CNT = (PULSE_CYCLES > GAP_CYCLES + 2) ? PULSE_CYCLES : GAP_CYCLES + 2;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] FLUSH_LD = CW'(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_BUS_ACT, S_BUS_GAP, S_INTA1, S_GAP1, S_INTA2, S_GAP2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_write_q, is_write_d;
   logic          int_meta_q, int_meta_d;
   logic          int_sync_q, int_sync_d;
   logic          inta_b_q, inta_b_d;
   logic          rd_b_q, rd_b_d;
   logic          wr_b_q, wr_b_d;
   logic          cs_b_q, cs_b_d;
   logic          a0_q, a0_d;
   logic          a0_lat;
   logic [7:0]    dout_q, dout_d;
   logic          oe_q, oe_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic [7:0]    vector_q, vector_d;
   logic          vector_valid_q, vector_valid_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      is_write_d     = is_write_q;
      dout_d         = dout_q;
      a0_lat         = a0_q;
      rd_data_d      = rd_data_q;
      vector_d       = vector_q;
      rd_valid_d     = 1'b0;
      vector_valid_d = 1'b0;
      int_meta_d     = INT;
      int_sync_d     = int_meta_q;

      case (state_q)
         S_IDLE: begin
            // A pending interrupt always pre-empts a host command.
            if (int_sync_q && irq_enable) begin
               state_d = S_INTA1;
               cnt_d   = PULSE_LD;
            end else if (cmd_valid) begin
               state_d    = S_BUS_ACT;
               cnt_d      = PULSE_LD;
               is_write_d = cmd_write;
               dout_d     = cmd_data;
               a0_lat     = cmd_a0;
            end
         end
         S_BUS_ACT: begin
            if (cnt_q == '0) begin
               state_d = S_BUS_GAP;
               cnt_d   = GAP_LD;
               if (!is_write_q) begin
                  rd_data_d  = data_in;
                  rd_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_BUS_GAP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_INTA1: begin
            if (cnt_q == '0) begin
               state_d = S_GAP1;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP1: begin
            if (cnt_q == '0) begin
               state_d = S_INTA2;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_INTA2: begin
            if (cnt_q == '0) begin
               state_d        = S_GAP2;
               cnt_d          = FLUSH_LD;
               vector_d       = data_in;
               vector_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP2: begin
            // Two extra cycles let a dropped INT clear the synchronizer.
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      inta_b_d = !((state_d == S_INTA1) || (state_d == S_INTA2));
      cs_b_d   = (state_d != S_BUS_ACT);
      rd_b_d   = !((state_d == S_BUS_ACT) && !is_write_d);
      wr_b_d   = !((state_d == S_BUS_ACT) && is_write_d);
      oe_d     = (state_d == S_BUS_ACT) && is_write_d;
      a0_d     = (state_d == S_BUS_ACT) && a0_lat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         is_write_q     <= 1'b0;
         int_meta_q     <= 1'b0;
         int_sync_q     <= 1'b0;
         inta_b_q       <= 1'b1;
         rd_b_q         <= 1'b1;
         wr_b_q         <= 1'b1;
         cs_b_q         <= 1'b1;
         a0_q           <= 1'b0;
         dout_q         <= 8'h00;
         oe_q           <= 1'b0;
         rd_data_q      <= 8'h00;
         rd_valid_q     <= 1'b0;
         vector_q       <= 8'h00;
         vector_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         is_write_q     <= is_write_d;
         int_meta_q     <= int_meta_d;
         int_sync_q     <= int_sync_d;
         inta_b_q       <= inta_b_d;
         rd_b_q         <= rd_b_d;
         wr_b_q         <= wr_b_d;
         cs_b_q         <= cs_b_d;
         a0_q           <= a0_d;
         dout_q         <= dout_d;
         oe_q           <= oe_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
         vector_q       <= vector_d;
         vector_valid_q <= vector_valid_d;
      end
   end

   assign cmd_ready    = (state_q == S_IDLE) && !(int_sync_q && irq_enable);
   assign INTA         = inta_b_q;
   assign RD           = rd_b_q;
   assign WR           = wr_b_q;
   assign CS           = cs_b_q;
   assign A0           = a0_q;
   assign data_out     = dout_q;
   assign data_oe      = oe_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign vector       = vector_q;
   assign vector_valid = vector_valid_q;

endmodule

// File: doc/pic_host_interface.md
# pic_host_interface

CPU-side bus master for the 8259A PIC: sits on the processor side of the PIC pins and drives the PIC's RD/WR/A0/CS/INTA inputs. It executes queued register writes and reads (ICW/OCW programming, IRR/ISR/IMR status reads) and, on a PIC INT request, autonomously runs the two-pulse INTA acknowledge sequence. It captures the interrupt vector the PIC places on D0–D7 and hands it to the host logic. The tri-state for the shared data bus is built at the top level from data_out/data_oe.

## Interface
Parameters:
- PULSE_CYCLES, 2, clock cycles each active-low strobe (RD/WR/INTA) is held low; must be ≥1
- GAP_CYCLES, 2, minimum inactive cycles after every strobe; must be ≥1

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host requests a bus cycle
- cmd_ready  out  1  command accepted on a cycle where cmd_valid & cmd_ready
- cmd_write  in  1  1 = write cycle, 0 = read cycle
- cmd_a0  in  1  A0 value for the cycle
- cmd_data  in  8  write data
- rd_data  out  8  last read result
- rd_valid  out  1  one-cycle pulse when rd_data updates
- irq_enable  in  1  permits automatic acknowledge of INT
- vector  out  8  last captured interrupt vector
- vector_valid  out  1  one-cycle pulse when vector updates
- INT  in  1  PIC interrupt request, asynchronous
- INTA  out  1  interrupt acknowledge to PIC, active low
- RD  out  1  read strobe, active low
- WR  out  1  write strobe, active low
- CS  out  1  chip select, active low
- A0  out  1  address bit
- data_out  out  8  value driven onto D0–D7
- data_oe  out  1  1 = drive data_out onto D0–D7
- data_in  in  8  sampled D0–D7

## Operation
- INT passes through a 2-flop synchronizer (int_sync). No other input is synchronized.
- States: IDLE, BUS_ACT, BUS_GAP, INTA1, GAP1, INTA2, GAP2.
- IDLE arbitration: if int_sync & irq_enable, go to INTA1; else if cmd_valid, accept and go to BUS_ACT. INT always wins.
- cmd_ready = (state==IDLE) & !(int_sync & irq_enable). This is combinational from registered state.
- BUS_ACT, write: CS=0, WR=0, A0=cmd_a0 (latched), data_oe=1, data_out=cmd_data (latched) for PULSE_CYCLES cycles.
- BUS_ACT, read: CS=0, RD=0, A0 latched, data_oe=0. data_in is sampled on the edge that ends the last low cycle.
- BUS_GAP: all strobes high, CS=1, data_oe=0, A0=0 for GAP_CYCLES, then IDLE.
- INTA1 (INTA=0, PULSE_CYCLES cycles) → GAP1 (GAP_CYCLES) → INTA2 (INTA=0, PULSE_CYCLES) → GAP2 (GAP_CYCLES+2 cycles, to flush the synchronizer) → IDLE.
- CS stays 1 and data_oe stays 0 throughout the acknowledge sequence.
- vector is loaded from data_in on the edge ending INTA2. vector_valid pulses on the following cycle.
- Once INTA1 is entered, the sequence runs to completion regardless of irq_enable or INT. This keeps the PIC protocol intact.
- If int_sync is still high in IDLE after GAP2, a new sequence starts (next pending interrupt).
- rd_data and vector hold their values until the next update.
- Pulse-width and gap counters are sized for the larger of the two parameters. No strobe is ever shorter than PULSE_CYCLES.

## Timing
- Reset (asynchronous, immediate):
  - INTA=RD=WR=CS=1, A0=0, data_oe=0, data_out=0.
  - rd_data=0, vector=0, rd_valid=0, vector_valid=0.
  - int_sync=0, FSM=IDLE.
  - A mid-cycle strobe is released at once, and no pulse output is generated.
- Bus cycle (cycle 0 = accept edge, P=PULSE_CYCLES, G=GAP_CYCLES):
  - Strobe/CS low in cycles 1..P.
  - Inactive in cycles P+1..P+G.
  - rd_valid high in cycle P+1.
  - cmd_ready can be high again at cycle P+G+1.
  - With defaults: low 1–2, rd_valid 3, ready 5.
- Acknowledge:
  - INT rises before edge k → int_sync high after edge k+1 → INTA low from edge k+2 (cycle 1 of the sequence).
  - INTA low 1..P and P+G+1..2P+G.
  - vector_valid in cycle 2P+G+1.
  - IDLE at cycle 2P+2G+3.
  - With defaults: INTA low 1–2 and 5–6, vector_valid 7, IDLE 11.
- All outputs except cmd_ready are registered.

## Test plan
- Reset with INT=1, cmd_valid=1 → all strobes/CS =1, data_oe=0, vector/rd_data=0, no pulses; after release, INTA first falls 3 cycles after the reset-release edge.
- Write cmd_write=1, cmd_a0=0, cmd_data=0x13 → CS=WR=0, data_oe=1, data_out=0x13, A0=0 in cycles 1–2; all inactive in 3–4; cmd_ready=1 in cycle 5.
- Read cmd_write=0, cmd_a0=1, data_in=0xA5 during RD low → RD=CS=0, A0=1 in cycles 1–2; rd_valid=1 with rd_data=0xA5 in cycle 3, then held.
- INT=1, irq_enable=1, data_in=0x48 during the second pulse (0xFF elsewhere) → INTA low in cycles 1–2 and 5–6, CS=1 throughout; vector=0x48 with vector_valid in cycle 7; no retrigger after INT drops.
- INT and cmd_valid together in IDLE → full INTA sequence first with cmd_ready=0; the write is accepted only after GAP2 completes and ends with data intact.
- Reset asserted in cycle 5 (second INTA low) → INTA=1 immediately, no vector_valid, vector=0; INT still high after release → a fresh full two-pulse sequence.
